// File: rtl/tmds_serializer_ddr.sv
// Four-lane TMDS DDR serializer: qualifies PLL lock, loads one 10-bit symbol per
// lane every 5 bit-clock cycles and presents 2 bits per cycle as rise/fall pairs.
module tmds_serializer_ddr #(
    parameter int LOCK_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic [9:0] sym0,
    input  logic [9:0] sym1,
    input  logic [9:0] sym2,
    output logic       load,
    output logic       ready,
    output logic [3:0] out_rise,
    output logic [3:0] out_fall
);
    localparam int CW = $clog2(LOCK_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);
    localparam logic [9:0] CLK_PATTERN = 10'b0000011111;

    typedef enum logic {ST_WAIT, ST_RUN} state_t;

    state_t          state;
    logic            sync1;
    logic            lock_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      phase;
    logic [3:0][9:0] lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_locked;
            lock_s <= sync1;
        end
    end

    // load depends only on flops, so upstream sees a glitch-free strobe
    always_comb begin
        load = 1'b0;
        if (lock_s) begin
            if (state == ST_WAIT) load = (cnt == CNT_LAST);
            else                  load = (phase == 3'd4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT;
            ready <= 1'b0;
            cnt   <= '0;
            phase <= '0;
            lane  <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    phase <= '0;
                    lane  <= '0;
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt < CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                        cnt   <= '0;
                        lane  <= {CLK_PATTERN, sym2, sym1, sym0};
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state <= ST_WAIT;
                        ready <= 1'b0;
                        cnt   <= '0;
                        phase <= '0;
                        lane  <= '0;
                    end else if (load) begin
                        phase <= '0;
                        lane  <= {CLK_PATTERN, sym2, sym1, sym0};
                    end else begin
                        phase <= phase + 3'd1;
                        for (int unsigned i = 0; i < 4; i++) begin
                            lane[i] <= {2'b00, lane[i][9:2]};
                        end
                    end
                end
                default: begin
                    state <= ST_WAIT;
                    ready <= 1'b0;
                    cnt   <= '0;
                    phase <= '0;
                    lane  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        out_rise = '0;
        out_fall = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            out_rise[i] = lane[i][0];
            out_fall[i] = lane[i][1];
        end
    end
endmodule

// File: doc/tmds_serializer_ddr.md
# tmds_serializer_ddr

Four-lane TMDS serializer in the 125 MHz bit-clock domain, directly downstream of the HDMI PLL (25 MHz reference, 125 MHz out, 5× pixel clock). It qualifies the PLL lock, samples one 10-bit TMDS symbol per data lane every 5 cycles, and shifts out 2 bits per cycle as rise/fall pairs for the DDR output cells, which gives 250 Mb/s per lane. Lane 3 carries the generated TMDS clock pattern. The upstream TMDS encoders feed it; the SB_IO DDR pads consume it.

## Interface
- `LOCK_WAIT`, default 16: consecutive synchronized-lock cycles required before running; legal range ≥1.
- `clk`  in  1: 125 MHz bit clock (PLL `clock_out`).
- `reset`  in  1: reset, asynchronous and active-high.
- `pll_locked`  in  1: PLL lock, asynchronous to `clk`; passes through a 2-FF synchronizer to give `lock_s`.
- `sym0`, `sym1`, `sym2`  in  10 each: TMDS symbols for lanes 0–2; sampled on the edge that ends a `load` cycle.
- `load`  out  1: one-cycle strobe; upstream must hold `symN` valid during this cycle.
- `ready`  out  1: high while in RUN.
- `out_rise`  out  4: per-lane bit driven on the rising half (even bit index); bit 3 is the clock lane.
- `out_fall`  out  4: per-lane bit driven on the falling half (odd bit index).

## Operation
- States:
  - WAIT: counter `cnt` has width clog2(LOCK_WAIT+1), shift registers are held at 0, phase = 0.
  - RUN: 3-bit `phase` cycles 0→1→2→3→4→0.
- WAIT:
  - `lock_s` = 0 → `cnt` ← 0.
  - `lock_s` = 1 and `cnt` < LOCK_WAIT−1 → `cnt` ← `cnt`+1.
  - `lock_s` = 1 and `cnt` = LOCK_WAIT−1 → `load` = 1 this cycle; next state is RUN, `phase` ← 0, shift registers ← symbols.
- RUN:
  - `load` = 1 exactly when `phase` = 4 and `lock_s` = 1.
  - `phase` = 4 → shift registers ← `{clk pattern, sym2, sym1, sym0}`.
  - Otherwise each lane register ← register >> 2, zero-filled.
  - Clock-lane pattern is 10'b0000011111, loaded LSB first.
- Outputs: `out_rise[n]` = lane register n bit 0; `out_fall[n]` = lane register n bit 1. Both are register outputs with no combinational path from inputs.
- Symbol bit order: bit 0 is transmitted first.
  - Phase k carries bit 2k on rise and bit 2k+1 on fall.
- Lock loss: `lock_s` = 0 while in RUN, at any phase →
  - `load` = 0 that cycle;
  - next state is WAIT with `cnt` = 0 and `phase` = 0;
  - shift registers are cleared, so outputs are 0 from the next cycle.
  - A partially sent symbol is abandoned.
- Clock lane per phase, as (rise,fall): 0:(1,1), 1:(1,1), 2:(1,0), 3:(0,0), 4:(0,0).

## Timing
- Reset values: `load` = 0, `ready` = 0, `out_rise` = 0, `out_fall` = 0. Internally state = WAIT, `cnt` = 0, `phase` = 0, synchronizer flops = 0.
- Reset asserted mid-operation: outputs go to 0 immediately, without waiting for `clk`.
- Lock latency, counting `pll_locked` as first sampled high at edge 1:
  - `lock_s` is high after edge 2.
  - `load` is high after edge LOCK_WAIT+1.
  - `ready` and bits 0/1 of the first symbols appear after edge LOCK_WAIT+2.
  - With the default LOCK_WAIT = 16, these are edges 17 and 18.
- Steady state:
  - `load` period is exactly 5 cycles with a 20% duty cycle.
  - A symbol sampled at edge E appears on the outputs during the 5 cycles after E.
  - Symbols are gap-free back to back.
- Lock drop: `pll_locked` falling is seen as `lock_s` = 0 two edges later, and `ready`/outputs reach 0 one edge after that.
- A lock glitch shorter than LOCK_WAIT during WAIT restarts the count from 0.

## Test plan
- Reset:
  - Stimulus: assert `reset` asynchronously mid-cycle while in RUN.
  - Required response: all outputs 0 with no `clk` edge; after release with `pll_locked` = 0, they stay 0 for 100 cycles.
- Lock qualification:
  - Stimulus: LOCK_WAIT = 16; `pll_locked` rises before edge 1.
  - Required response: `load` is a single pulse after edge 17; `ready` rises after edge 18.
- Data lanes:
  - Stimulus: `sym0` = 10'h2AB, `sym1` = 10'h154, `sym2` = 10'h3FF, constant.
  - Required response: lane 0 (rise,fall) per phase = (1,1),(0,1),(0,1),(0,1),(0,1). Lane 1 shows the complement pattern, lane 2 is all 1, and `load` occurs every 5th cycle.
- Clock lane:
  - Stimulus: 20 running cycles.
  - Required response: (1,1),(1,1),(1,0),(0,0),(0,0) repeating, aligned with phase 0 following each `load`.
- Lock loss:
  - Stimulus: drop `pll_locked` at phase 2.
  - Required response: outputs are 0 three edges later; re-raising lock gives `ready` LOCK_WAIT+2 edges after the new rise.
- Glitch:
  - Stimulus: during WAIT, drop `pll_locked` for 1 cycle when `cnt` = 10.
  - Required response: `cnt` restarts at 0; `load` occurs only after 16 further consecutive `lock_s` cycles.
